wishbone_1mst_to_nslv: RTL

Parametrised successor to the fixed 4-slave Wishbone splitter in the user project top. Routes one Wishbone classic master (Caravel wbs_*) to NB_SLV peripheral slaves by base/mask address decode. Registers every request, enforces a single outstanding transaction, and answers both unmapped addresses and hung slaves with an error response plus an interrupt pulse, so the management SoC never stalls. Sits between the Caravel wishbone port and the peripherals (string LED, step motor, NEC IR, pseudorandom, …).

---
 rtl/wishbone_nslv_pkg.sv | 21 ++
 rtl/wb_addr_decoder.sv | 28 ++
 rtl/wishbone_1mst_to_nslv.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/wishbone_nslv_pkg.sv
// Shared types and constants for the one-master to N-slave Wishbone splitter.
package wishbone_nslv_pkg;

    localparam int WB_DW = 32;
    localparam int WB_AW = 32;

    localparam logic [WB_DW-1:0] ERR_DATA_DEF = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        RESP     = 2'd2,
        RESP_ERR = 2'd3
    } wb_state_e;

    // A one-slave build still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational base/mask address decode; the lowest matching slave index wins.
module wb_addr_decoder
    import wishbone_nslv_pkg::*;
#(
    parameter int                        NB_SLV    = 4,
    parameter logic [NB_SLV*WB_AW-1:0]   ADDR_BASE = {32'h30030000, 32'h30020000, 32'h30010000, 32'h30000000},
    parameter logic [NB_SLV*WB_AW-1:0]   ADDR_MASK = {4{32'hFFFF0000}},
    localparam int                       IDX_W     = idx_width(NB_SLV)
)(
    input  logic [WB_AW-1:0] i_adr,
    output logic             o_hit,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        // Walk from the top so the lowest index is the last one written.
        for (int i = NB_SLV - 1; i >= 0; i--) begin
            if ((i_adr & ADDR_MASK[i*WB_AW +: WB_AW]) ==
                (ADDR_BASE[i*WB_AW +: WB_AW] & ADDR_MASK[i*WB_AW +: WB_AW])) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/wishbone_1mst_to_nslv.sv
// Routes one Wishbone classic master to NB_SLV slaves with one outstanding access,
// answering unmapped addresses and hung slaves with an error ack and interrupt pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for cyc&stb; request latched on the sampling edge
// ACTIVE   | selected slave strobed, waiting for its ack or the timeout
// RESP     | master ack high this cycle with the slave's read data
// RESP_ERR | next edge raises master ack with ERR_DATA and pulses err_irq
module wishbone_1mst_to_nslv
    import wishbone_nslv_pkg::*;
#(
    parameter int                        NB_SLV    = 4,
    parameter logic [NB_SLV*WB_AW-1:0]   ADDR_BASE = {32'h30030000, 32'h30020000, 32'h30010000, 32'h30000000},
    parameter logic [NB_SLV*WB_AW-1:0]   ADDR_MASK = {4{32'hFFFF0000}},
    parameter int                        TIMEOUT   = 255,
    parameter logic [WB_DW-1:0]          ERR_DATA  = ERR_DATA_DEF
)(
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_m_cyc_i,
    input  logic                      wbs_m_stb_i,
    input  logic                      wbs_m_we_i,
    input  logic [3:0]                wbs_m_sel_i,
    input  logic [WB_AW-1:0]          wbs_m_adr_i,
    input  logic [WB_DW-1:0]          wbs_m_dat_i,
    output logic                      wbs_m_ack_o,
    output logic [WB_DW-1:0]          wbs_m_dat_o,
    output logic [NB_SLV-1:0]         wbs_s_cyc_o,
    output logic [NB_SLV-1:0]         wbs_s_stb_o,
    output logic                      wbs_s_we_o,
    output logic [3:0]                wbs_s_sel_o,
    output logic [WB_AW-1:0]          wbs_s_adr_o,
    output logic [WB_DW-1:0]          wbs_s_dat_o,
    input  logic [NB_SLV*WB_DW-1:0]   wbs_s_dat_i,
    input  logic [NB_SLV-1:0]         wbs_s_ack_i,
    output logic                      err_irq,
    output logic [WB_AW-1:0]          err_adr
);

    localparam int IDX_W = idx_width(NB_SLV);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    wb_state_e          r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_cnt;
    logic [NB_SLV-1:0]  r_s_req;
    logic               r_m_ack;
    logic [WB_DW-1:0]   r_m_dat;
    logic               r_s_we;
    logic [3:0]         r_s_sel;
    logic [WB_AW-1:0]   r_s_adr;
    logic [WB_DW-1:0]   r_s_dat;
    logic               r_err_irq;
    logic [WB_AW-1:0]   r_err_adr;

    logic               w_hit;
    logic [IDX_W-1:0]   w_idx;
    logic               w_sel_ack;
    logic [WB_DW-1:0]   w_sel_dat;
    logic [NB_SLV-1:0]  w_onehot;

    wb_addr_decoder #(
        .NB_SLV    (NB_SLV),
        .ADDR_BASE (ADDR_BASE),
        .ADDR_MASK (ADDR_MASK)
    ) u_dec (
        .i_adr (wbs_m_adr_i),
        .o_hit (w_hit),
        .o_idx (w_idx)
    );

    // Only an ack from the slave we are actually strobing counts.
    assign w_sel_ack = wbs_s_ack_i[r_idx] & r_s_req[r_idx];
    assign w_sel_dat = wbs_s_dat_i[r_idx*WB_DW +: WB_DW];
    assign w_onehot  = NB_SLV'(1) << r_idx;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_s_req   <= '0;
            r_m_ack   <= 1'b0;
            r_m_dat   <= '0;
            r_s_we    <= 1'b0;
            r_s_sel   <= '0;
            r_s_adr   <= '0;
            r_s_dat   <= '0;
            r_err_irq <= 1'b0;
            r_err_adr <= '0;
        end else begin
            r_m_ack   <= 1'b0;
            r_err_irq <= 1'b0;
            case (r_state)
                IDLE: begin
                    // While an error ack is still on the bus the master has not yet dropped stb.
                    if (wbs_m_cyc_i && wbs_m_stb_i && !r_m_ack) begin
                        r_s_adr <= wbs_m_adr_i;
                        r_s_dat <= wbs_m_dat_i;
                        r_s_sel <= wbs_m_sel_i;
                        r_s_we  <= wbs_m_we_i;
                        r_idx   <= w_idx;
                        r_cnt   <= '0;
                        r_state <= w_hit ? ACTIVE : RESP_ERR;
                    end
                end
                ACTIVE: begin
                    if (!wbs_m_cyc_i) begin
                        r_s_req <= '0;
                        r_state <= IDLE;
                    end else if (w_sel_ack) begin
                        r_m_dat <= w_sel_dat;
                        r_m_ack <= 1'b1;
                        r_s_req <= '0;
                        r_state <= RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_s_req <= '0;
                        r_state <= RESP_ERR;
                    end else begin
                        r_s_req <= w_onehot;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                RESP_ERR: begin
                    r_m_ack   <= 1'b1;
                    r_m_dat   <= ERR_DATA;
                    r_err_irq <= 1'b1;
                    r_err_adr <= r_s_adr;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wbs_m_ack_o = r_m_ack;
    assign wbs_m_dat_o = r_m_dat;
    assign wbs_s_cyc_o = r_s_req;
    assign wbs_s_stb_o = r_s_req;
    assign wbs_s_we_o  = r_s_we;
    assign wbs_s_sel_o = r_s_sel;
    assign wbs_s_adr_o = r_s_adr;
    assign wbs_s_dat_o = r_s_dat;
    assign err_irq     = r_err_irq;
    assign err_adr     = r_err_adr;

endmodule
